cordic_vectoring_engine: RTL
============================

CORDIC_VECTORING_ENGINE -- requirements
Module: cordic_vectoring_engine

Interface
REQ-001 Parameter FIXED_WIDTH, default 16: width of the x/y inputs and of ROM angle words (signed, 14 fractional bits; pi/2 = 25736).
REQ-002 Parameter ITERATIONS, default 9: number of micro-rotations; the ROM index width is IW = $clog2(ITERATIONS)+1.
REQ-003 Port clk: input, 1 bit, single clock; all state changes on the rising edge.
REQ-004 Port rst_n: input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port start: input, 1 bit; request a new conversion, sampled only in IDLE.
REQ-006 Ports x_in and y_in: input, FIXED_WIDTH bits each, signed vector components; captured on the accepted start edge.
REQ-007 Port rom_idx: output, IW bits; arctangent ROM address equal to the current iteration number.
REQ-008 Port rom_angle: input, FIXED_WIDTH bits, signed; atan(2^-rom_idx) returned combinationally by an external ROM in the same cycle.
REQ-009 Port busy: output, 1 bit; high while a conversion is in progress.
REQ-010 Port done: output, 1 bit; single-cycle pulse marking the result as valid.
REQ-011 Port angle_out: output, FIXED_WIDTH+1 bits, signed; atan2(y,x) in the same scale as the ROM, range about +/-51472.
REQ-012 Port mag_out: output, FIXED_WIDTH+1 bits, unsigned; CORDIC-gain-scaled magnitude, about 1.6468*sqrt(x^2+y^2).

Function
REQ-013 The FSM SHALL have three states: IDLE, ITER and DONE.
REQ-014 IDLE with start=1 at edge E0: load pre-rotated registers and counter i=0, move to ITER, set busy=1.
REQ-015 IDLE with start=0: all registers hold.
REQ-016 Pre-rotation when x_in>=0: x0=x_in, y0=y_in, z0=0.
REQ-017 Pre-rotation when x_in<0 and y_in>=0: x0=y_in, y0=-x_in, z0=+25736.
REQ-018 Pre-rotation when x_in<0 and y_in<0: x0=-y_in, y0=x_in, z0=-25736.
REQ-019 Internal x and y SHALL be FIXED_WIDTH+2 bits signed; z SHALL be FIXED_WIDTH+1 bits signed; inputs and rom_angle are sign-extended; no saturation.
REQ-020 ITER, case y>=0, on each edge: x<=x+(y>>>i); y<=y-(x>>>i); z<=z+rom_angle. Shifts are arithmetic and use the pre-edge values.
REQ-021 ITER, case y<0, on each edge: x<=x-(y>>>i); y<=y+(x>>>i); z<=z-rom_angle.
REQ-022 ITER SHALL then set i<=i+1; after the update with i=ITERATIONS-1 (edge E_ITERATIONS), move to DONE.
REQ-023 rom_idx SHALL equal i in ITER and SHALL be 0 in IDLE and DONE.
REQ-024 On entry to DONE, register angle_out<=z and mag_out<=x[FIXED_WIDTH:0], set done=1 and busy=0.
REQ-025 DONE SHALL last exactly one cycle, then return to IDLE with done=0.
REQ-026 Latency SHALL be fixed: done is high in the cycle after edge E_ITERATIONS, i.e. ITERATIONS+1 edges after E0, with no data dependence.
REQ-027 angle_out and mag_out SHALL hold their values until the next DONE entry.
REQ-028 start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-029 start held high continuously SHALL launch back-to-back conversions, one per ITERATIONS+2 cycles.
REQ-030 x_in=y_in=0 SHALL give mag_out=0 and angle_out equal to the sum of ROM words 0..ITERATIONS-1, since y>=0 on every step.

Reset
REQ-031 Asserting rst_n low SHALL immediately force: state=IDLE, i=0, x=y=z=0, busy=0, done=0, angle_out=0, mag_out=0, rom_idx=0.
REQ-032 A reset during ITER or DONE SHALL abort the conversion with no done pulse; the first start after rst_n rises is accepted normally.

Verification
REQ-033 Reset check: pulse rst_n low mid-ITER -> all outputs 0 in that cycle; no done pulse afterwards; a new start gives a correct result.
REQ-034 x=16384, y=0 -> angle_out 0+/-80; mag_out 26981+/-40; done exactly 10 edges after start, busy high for 9 cycles (defaults).
REQ-035 x=y=16384 -> angle_out 12868+/-80.
REQ-036 x=-16384, y=0 -> angle_out 51472+/-80.
REQ-037 x=0, y=-16384 -> angle_out -25736+/-80.
REQ-038 start pulsed at cycles 3 and 5 of a conversion -> ignored; exactly one done pulse; rom_idx sequence 0,1,...,8 then 0.
REQ-039 x=y=0 -> mag_out 0 and angle_out equal to the ROM sum.
REQ-040 start held high -> done pulses every 11 cycles.

Source files
------------

// File: rtl/cordic_vectoring_engine.sv
// Iterative CORDIC in vectoring mode: rotates (x,y) onto the +x axis and
// accumulates the angle from an external arctangent ROM, one micro-rotation per clock.
module cordic_vectoring_engine #(
  parameter  int FIXED_WIDTH = 16,
  parameter  int ITERATIONS  = 9,
  localparam int IW          = $clog2(ITERATIONS) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [FIXED_WIDTH-1:0] x_in,
  input  logic signed [FIXED_WIDTH-1:0] y_in,
  output logic        [IW-1:0]          rom_idx,
  input  logic signed [FIXED_WIDTH-1:0] rom_angle,
  output logic                          busy,
  output logic                          done,
  output logic signed [FIXED_WIDTH:0]   angle_out,
  output logic        [FIXED_WIDTH:0]   mag_out
);

  localparam int XW = FIXED_WIDTH + 2;
  localparam int ZW = FIXED_WIDTH + 1;
  localparam logic signed [ZW-1:0] HALF_PI = ZW'(25736);
  localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic        [IW-1:0] i;
  logic signed [XW-1:0] x, y;
  logic signed [ZW-1:0] z;

  logic signed [XW-1:0] x_ext, y_ext, x0, y0, x_sh, y_sh, x_nxt, y_nxt;
  logic signed [ZW-1:0] z0, rom_ext, z_nxt;

  // i is cleared when leaving ITER, so it doubles as the ROM address
  // and reads 0 in IDLE and DONE without extra gating.
  assign rom_idx = i;

  always_comb begin
    x_ext   = XW'(x_in);
    y_ext   = XW'(y_in);
    rom_ext = ZW'(rom_angle);

    // Quadrant pre-rotation by +/-90 degrees brings the vector into the right half-plane
    if (!x_in[FIXED_WIDTH-1]) begin
      x0 = x_ext;
      y0 = y_ext;
      z0 = '0;
    end else if (!y_in[FIXED_WIDTH-1]) begin
      x0 = y_ext;
      y0 = -x_ext;
      z0 = HALF_PI;
    end else begin
      x0 = -y_ext;
      y0 = x_ext;
      z0 = -HALF_PI;
    end

    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!y[XW-1]) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + rom_ext;
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - rom_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x     <= x0;
            y     <= y0;
            z     <= z0;
            i     <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          if (i == LAST) begin
            i         <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            angle_out <= z_nxt;
            mag_out   <= x_nxt[FIXED_WIDTH:0];
            state     <= DONE;
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
